// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, FSM state encoding and instruction classes
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_DECODE = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3} state_t;
  typedef enum logic [2:0] {CLS_ALU, CLS_ADDI, CLS_BEQ, CLS_J, CLS_ILLEGAL} cls_t;
endpackage

// File: rtl/mips_decode.sv
// mips_decode: splits the latched instruction into class, register fields, immediate and jump target
module mips_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [27:0] jump_target
);
  logic [5:0] op, fn;
  assign op          = ir[31:26];
  assign fn          = ir[5:0];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
  assign jump_target = {ir[25:0], 2'b00};
  // classify by opcode; R-type is only legal for the five ALU functs
  always_comb
    cls = (op == OP_RTYPE) ? ((fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) ? CLS_ALU : CLS_ILLEGAL) :
          (op == OP_ADDI)  ? CLS_ADDI :
          (op == OP_BEQ)   ? CLS_BEQ  :
          (op == OP_J)     ? CLS_J    : CLS_ILLEGAL;
endmodule

// File: rtl/mips_control.sv
// mips_control: multi-cycle fetch/decode/exec/writeback sequencer owning PC and IR
module mips_control
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC            = 32'h0000_0000,
  parameter bit          ENABLE_ILLEGAL_FLAG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  output logic [4:0]  write_register,
  output logic        reg_write,
  output logic        alu_src_imm,
  output logic        illegal,
  output logic [1:0]  state
);
  state_t      st;
  cls_t        cls;
  logic [4:0]  rs, rt, rd, wsel;
  logic [31:0] imm_sext, pc_plus4;
  logic [27:0] jump_target;
  mips_decode u_decode (
    .ir          (ir),
    .cls         (cls),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm_sext    (imm_sext),
    .jump_target (jump_target)
  );
  assign state    = st;
  assign pc_plus4 = pc + 32'd4;
  assign wsel     = (cls == CLS_ALU) ? rd : rt;
  // FSM with registered outputs; reg_write and illegal are pulses raised for the WB and EXEC cycles
  always_ff @(posedge clk)
    if (!rst) begin
      st             <= S_FETCH;
      pc             <= RESET_PC;
      ir             <= '0;
      RA             <= '0;
      RB             <= '0;
      write_register <= '0;
      reg_write      <= 1'b0;
      alu_src_imm    <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      illegal   <= 1'b0;
      case (st)
        S_FETCH: if (run) begin
          ir <= instruction;
          st <= S_DECODE;
        end
        S_DECODE: begin
          RA          <= rs;
          RB          <= rt;
          alu_src_imm <= cls == CLS_ADDI;
          illegal     <= ENABLE_ILLEGAL_FLAG && (cls == CLS_ILLEGAL);
          st          <= S_EXEC;
        end
        S_EXEC: case (cls)
          CLS_ALU, CLS_ADDI: begin
            write_register <= wsel;
            reg_write      <= wsel != 5'd0;
            st             <= S_WB;
          end
          CLS_BEQ: begin
            pc <= alu_zero ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
            st <= S_FETCH;
          end
          CLS_J: begin
            pc <= {pc_plus4[31:28], jump_target};
            st <= S_FETCH;
          end
          default: begin
            pc <= pc_plus4;
            st <= S_FETCH;
          end
        endcase
        default: begin
          pc <= pc_plus4;
          st <= S_FETCH;
        end
      endcase
    end
endmodule

// File: tb/tb_mips_control.sv
// tb_mips_control: table-driven scoreboard bench for the mips_control sequencer
module tb_mips_control;
  logic        clk = 1'b0, rst = 1'b0, run = 1'b0, alu_zero = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] pc, ir;
  logic [4:0]  RA, RB, write_register;
  logic        reg_write, alu_src_imm, illegal;
  logic [1:0]  state;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  ra, rb, wr;
    logic        imm, we, ill;
    int          lat;
  } vec_t;

  vec_t tbl[17];
  vec_t exp_q[$];

  mips_control dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .instruction    (instruction),
    .alu_zero       (alu_zero),
    .pc             (pc),
    .ir             (ir),
    .RA             (RA),
    .RB             (RB),
    .write_register (write_register),
    .reg_write      (reg_write),
    .alu_src_imm    (alu_src_imm),
    .illegal        (illegal),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic zero, input logic [31:0] p, input logic [31:0] pn,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wr,
                              input logic imm, input logic we, input logic ill, input int lat);
    vec_t v;
    v.instr = instr; v.zero = zero; v.pc = p; v.pc_next = pn;
    v.ra = ra; v.rb = rb; v.wr = wr; v.imm = imm; v.we = we; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // caller is at a negedge with the DUT in S_FETCH and run about to be sampled high
  task automatic do_instr(input vec_t v, input int idx);
    int cyc = 0, rw = 0, il = 0;
    logic [4:0] ra = '0, rb = '0;
    logic imm = 1'b0;
    vec_t e;
    exp_q.push_back(v);
    chk($sformatf("v%0d pc_fetch", idx), pc, v.pc);
    instruction = v.instr;
    alu_zero = v.zero;
    run = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) instruction = $urandom;
      if (state == 2'd2) begin ra = RA; rb = RB; imm = alu_src_imm; end
      rw += int'(reg_write);
      il += int'(illegal);
    end while (state != 2'd0 && cyc < 10);
    e = exp_q.pop_front();
    chk($sformatf("v%0d latency", idx), cyc, e.lat);
    chk($sformatf("v%0d ir", idx), ir, e.instr);
    chk($sformatf("v%0d RA", idx), {27'd0, ra}, {27'd0, e.ra});
    chk($sformatf("v%0d RB", idx), {27'd0, rb}, {27'd0, e.rb});
    chk($sformatf("v%0d alu_src_imm", idx), {31'd0, imm}, {31'd0, e.imm});
    chk($sformatf("v%0d reg_write_pulses", idx), rw, {31'd0, e.we});
    chk($sformatf("v%0d illegal_pulses", idx), il, {31'd0, e.ill});
    if (e.lat == 4) chk($sformatf("v%0d write_register", idx), {27'd0, write_register}, {27'd0, e.wr});
    chk($sformatf("v%0d pc_next", idx), pc, e.pc_next);
  endtask

  initial begin
    int n, rw;
    tbl[0]  = mk(32'h20010005, 1'b0, 32'h0000_0000, 32'h0000_0004, 5'd0,  5'd1,  5'd1,  1'b1, 1'b1, 1'b0, 4);
    tbl[1]  = mk(32'h00221820, 1'b0, 32'h0000_0004, 32'h0000_0008, 5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b0, 4);
    tbl[2]  = mk(32'h1022FFFF, 1'b1, 32'h0000_0008, 32'h0000_0008, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[3]  = mk(32'h1022FFFF, 1'b0, 32'h0000_0008, 32'h0000_000C, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[4]  = mk(32'h00220020, 1'b0, 32'h0000_000C, 32'h0000_0010, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 4);
    tbl[5]  = mk(32'h00A62022, 1'b0, 32'h0000_0010, 32'h0000_0014, 5'd5,  5'd6,  5'd4,  1'b0, 1'b1, 1'b0, 4);
    tbl[6]  = mk(32'h01093824, 1'b0, 32'h0000_0014, 32'h0000_0018, 5'd8,  5'd9,  5'd7,  1'b0, 1'b1, 1'b0, 4);
    tbl[7]  = mk(32'h016C5025, 1'b0, 32'h0000_0018, 32'h0000_001C, 5'd11, 5'd12, 5'd10, 1'b0, 1'b1, 1'b0, 4);
    tbl[8]  = mk(32'h01CF682A, 1'b0, 32'h0000_001C, 32'h0000_0020, 5'd14, 5'd15, 5'd13, 1'b0, 1'b1, 1'b0, 4);
    tbl[9]  = mk(32'hFC000000, 1'b0, 32'h0000_0020, 32'h0000_0024, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 3);
    tbl[10] = mk(32'h00200000, 1'b0, 32'h0000_0024, 32'h0000_0028, 5'd1,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 3);
    tbl[11] = mk(32'h20400007, 1'b0, 32'h0000_0028, 32'h0000_002C, 5'd2,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 4);
    tbl[12] = mk(32'h10008000, 1'b1, 32'h0000_002C, 32'hFFFE_0030, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[13] = mk(32'h08000004, 1'b0, 32'hFFFE_0030, 32'hF000_0010, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[14] = mk(32'h08000040, 1'b0, 32'hF000_0010, 32'hF000_0100, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[15] = mk(32'h0BFFFFFF, 1'b0, 32'hF000_0100, 32'hFFFF_FFFC, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 3);
    tbl[16] = mk(32'h20A5FFFF, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 4);

    repeat (2) @(negedge clk);
    chk("rst pc", pc, 32'h0);
    chk("rst state", {30'd0, state}, 32'd0);
    chk("rst ir", ir, 32'h0);
    chk("rst selects", {17'd0, RA, RB, write_register}, 32'd0);
    chk("rst pulses", {29'd0, reg_write, alu_src_imm, illegal}, 32'd0);
    rst = 1'b1;
    instruction = 32'h20010005;
    repeat (5) @(negedge clk);
    chk("hold pc", pc, 32'h0);
    chk("hold ir", ir, 32'h0);
    chk("hold state", {30'd0, state}, 32'd0);

    foreach (tbl[i]) do_instr(tbl[i], i);
    run = 1'b0;

    instruction = 32'h00221820;
    run = 1'b1;
    @(negedge clk);
    chk("drop decode_state", {30'd0, state}, 32'd1);
    run = 1'b0;
    n = 0; rw = 0;
    while (state != 2'd0 && n < 10) begin
      @(negedge clk);
      n++;
      rw += int'(reg_write);
    end
    repeat (3) @(negedge clk);
    chk("drop reg_write_pulses", rw, 32'd1);
    chk("drop state", {30'd0, state}, 32'd0);
    chk("drop pc", pc, 32'h4);

    instruction = 32'h20010005;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("midrst exec_state", {30'd0, state}, 32'd2);
    rst = 1'b0;
    rw = 0;
    repeat (2) begin
      @(negedge clk);
      rw += int'(reg_write);
    end
    rst = 1'b1;
    chk("midrst reg_write", rw, 32'd0);
    chk("midrst pc", pc, 32'h0);
    chk("midrst state", {30'd0, state}, 32'd0);
    chk("midrst ir", ir, 32'h0);
    do_instr(tbl[0], 100);
    run = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
